// File: rtl/lmfe_pixel_feeder.sv
// rtl/lmfe_pixel_feeder.sv - streams a frame from 1-cycle-latency memory into the LMFE input port
module lmfe_pixel_feeder #(
  parameter int IMG_PIXELS = 16384,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              busy,
  output logic              in_en,
  output logic [DATA_W-1:0] Din,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     addr_q, sent_q;
  logic              in_flight;
  logic              head_vld, tail_vld;
  logic [DATA_W-1:0] head_q, tail_q;
  logic              pop, push;
  logic [2:0]        level;

  // Head register is Din itself, so the pixel is always registered and holds when empty
  assign pop      = in_en;
  assign push     = in_flight;
  assign in_en    = head_vld && !busy;
  assign Din      = head_q;
  assign mem_addr = addr_q[ADDR_W-1:0];
  assign level    = {2'b00, head_vld} + {2'b00, tail_vld} + {2'b00, in_flight} - {2'b00, pop};
  assign mem_rd   = (state_q == RUN) && (level < 3'd2);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (mem_rd && addr_q == LAST_IDX) state_d = DRAIN;
      DRAIN: if (pop && sent_q == LAST_IDX) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sent_q    <= '0;
      in_flight <= 1'b0;
      head_vld  <= 1'b0;
      tail_vld  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_flight <= mem_rd;
      if (state_q == IDLE && start) begin
        addr_q <= '0;
        sent_q <= '0;
      end else begin
        if (mem_rd) addr_q <= addr_q + CW'(1);
        if (pop)    sent_q <= sent_q + CW'(1);
      end
      // Two-entry FIFO: head feeds Din, tail catches the read that lands during a stall
      if (pop) begin
        if (tail_vld) begin
          head_q <= tail_q;
          if (push) tail_q <= mem_rdata;
          else      tail_vld <= 1'b0;
        end else if (push) begin
          head_q <= mem_rdata;
        end else begin
          head_vld <= 1'b0;
        end
      end else if (push) begin
        if (!head_vld) begin
          head_q   <= mem_rdata;
          head_vld <= 1'b1;
        end else begin
          tail_q   <= mem_rdata;
          tail_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// tb/tb_lmfe_pixel_feeder.sv - self-checking bench for lmfe_pixel_feeder
module tb_lmfe_pixel_feeder;
  localparam int N  = 16384;
  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy = 1'b0;
  logic          mem_rd, in_en, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] Din;
  logic [DW-1:0] golden [N];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          rst, st, bz, rd;
    logic [AW-1:0] addr;
    logic          en;
    logic [DW-1:0] din;
    logic          dn;
  } vec_t;

  vec_t tbl [13];

  lmfe_pixel_feeder #(.IMG_PIXELS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .in_en(in_en), .Din(Din), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= golden[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pixel k must be golden[k], reads in address order, at most two pixels outstanding
  task automatic run_frame(input int mode, input int abort_at);
    int en_cnt = 0, rd_cnt = 0, done_cnt = 0, last_en = -10, done_rel = 0;
    int bp = 0, endc = 0;
    bit fin = 0, aborted = 0;
    start = 1'b1;
    busy  = 1'b0;
    @(negedge clk);
    chk("start_cycle_in_en", in_en, 0);
    chk("start_cycle_mem_rd", mem_rd, 0);
    @(posedge clk); #1;
    for (int rel = 1; rel <= 3 * N + 200; rel++) begin
      start = (mode == 0) && (rel == 200 || rel == N + 3);
      case (mode)
        0: busy = 1'b0;
        1: begin
          busy = 1'b0;
          if (en_cnt >= 100 && bp < 55) begin
            busy = (bp < 5) ? 1'b1 : (bp % 2 == 0);
            bp++;
          end
          if (en_cnt == N - 2 && endc < 10) begin
            busy = 1'b1;
            endc++;
          end
        end
        default: busy = ($urandom_range(0, 3) == 0);
      endcase
      if (abort_at > 0 && en_cnt >= abort_at) begin
        reset = 1'b0;
        busy  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset_in_en", in_en, 0);
        chk("after_reset_mem_rd", mem_rd, 0);
        chk("after_reset_din", Din, 0);
        chk("after_reset_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (mode == 0) begin
        chk("freerun_in_en", in_en, rel >= 3 && rel <= N + 2);
        chk("freerun_mem_rd", mem_rd, rel >= 1 && rel <= N);
        chk("freerun_done", done, rel == N + 3);
      end
      if (in_en) begin
        chk("in_en_while_busy", busy, 0);
        chk("pixel_count_bound", en_cnt < N, 1);
        if (en_cnt < N) chk("din_order", Din, golden[en_cnt]);
        en_cnt++;
        last_en = rel;
      end
      if (mem_rd) begin
        chk("read_addr", mem_addr, rd_cnt);
        rd_cnt++;
        chk("outstanding_le2", (rd_cnt - en_cnt) <= 2, 1);
      end
      if (done) begin
        chk("done_all_consumed", en_cnt, N);
        chk("done_after_last_en", rel, last_en + 1);
        done_cnt++;
        done_rel = rel;
        chk("single_done", done_cnt, 1);
      end
      @(posedge clk); #1;
      if (done_cnt > 0 && rel >= done_rel + 20) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    busy  = 1'b0;
    if (!aborted) begin
      chk("frame_finished", fin, 1);
      chk("frame_pixels", en_cnt, N);
      chk("frame_reads", rd_cnt, N);
      chk("frame_done_pulses", done_cnt, 1);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) golden[k] = DW'(k % 256);
    //          rst   st    bz    rd    addr   en    din   dn
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd1, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd2, 1'b1, 8'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'd3, 1'b0, 8'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'd3, 1'b0, 8'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd3, 1'b1, 8'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd4, 1'b1, 8'd2, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd5, 1'b1, 8'd3, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 14'd6, 1'b0, 8'd4, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst;
      start = tbl[i].st;
      busy  = tbl[i].bz;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_rd", i), mem_rd, tbl[i].rd);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_in_en", i), in_en, tbl[i].en);
      chk($sformatf("vec%0d_din", i), Din, tbl[i].din);
      chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    start = 1'b0;
    busy  = 1'b0;

    run_frame(0, 0);
    run_frame(1, 0);
    for (int k = 0; k < N; k++) golden[k] = DW'($urandom);
    run_frame(2, 5000);
    run_frame(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lmfe_pixel_feeder.md
Name: lmfe_pixel_feeder

Overview:
Synthesizable pixel source that drives the LMFE median-filter input port (Din / in_en / busy) from an image held in a 1-cycle-latency synchronous memory. After a start pulse it streams IMG_PIXELS pixels in raster address order and honours LMFE's busy back-pressure. A 2-entry prefetch FIFO absorbs memory read latency so no pixel is lost or duplicated. It replaces the behavioural stimulus loop, so the filter can be driven on-chip or in gate-level runs.

Parameters:
IMG_PIXELS, 16384, number of pixels per frame (128x128)
ADDR_W, 14, memory address width; must satisfy 2**ADDR_W >= IMG_PIXELS
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
start  in  1  one-cycle frame start request; sampled only in IDLE
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  read address, valid when mem_rd=1
mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
busy  in  1  LMFE back-pressure; pixel not accepted while high
in_en  out  1  pixel valid to LMFE; pixel consumed in every cycle with in_en=1
Din  out  DATA_W  pixel to LMFE
done  out  1  one-cycle pulse after the last pixel is consumed

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; FIFO empty; in-flight flag=0; read address=0; sent count=0; done=0. Outputs: mem_rd=0, in_en=0, Din=0, mem_addr=0.
- Reset mid-frame: same as above on that edge. No in_en after it. Partial frame is abandoned, not resumed.
- FSM states and transitions:
  - IDLE: if start=1, go to RUN and clear address and counters. start is ignored in every other state.
  - RUN: issue reads. After the read of address IMG_PIXELS-1 is issued, go to DRAIN.
  - DRAIN: no reads. When sent count reaches IMG_PIXELS (FIFO empty, nothing in flight), go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Read issue:
  - mem_rd=1 in RUN when (occupancy + in_flight - pop) < 2, where pop = in_en this cycle.
  - mem_addr = current address; the address increments after each issued read.
  - mem_rd is never asserted outside RUN.
- Memory data: mem_rdata is pushed into the FIFO on the edge that ends the cycle after mem_rd.
- Output:
  - Din = FIFO head (registered, never driven directly from mem_rdata).
  - in_en = !fifo_empty && !busy. Combinational on busy, so the same-cycle value of busy controls it.
  - When in_en=0, Din holds the head value, or its last value if the FIFO is empty.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Ordering: pixel k presented to LMFE is memory word k, k=0..IMG_PIXELS-1, exactly once each.
- Latency: with busy held low, start is sampled at edge E0:
  - first mem_rd in cycle E0+1;
  - first in_en in cycle E0+3;
  - then one pixel per cycle;
  - last in_en in cycle E0+3+IMG_PIXELS-1;
  - done in the next cycle.
- Throughput: sustains 1 pixel/cycle with no bubbles while busy=0.
- Counters: the address and sent counter are ADDR_W+1 bits wide, with no wrap within a frame. A new start in IDLE restarts from address 0.

Test Plan:
- Reset values: hold reset=0 for 2 cycles -> mem_rd=0, in_en=0, Din=0, done=0, mem_addr=0.
- Free-run frame: memory word k = k mod 256, busy=0, start pulse at E0 -> in_en continuously high from E0+3 for 16384 cycles; Din sequence 00,01,...,FF repeated; done only at E0+16387.
- Back-pressure: busy high for 5 cycles at pixel 100, then every other cycle for 50 cycles -> in_en=0 whenever busy=1; no gap or repeat in the Din sequence; FIFO never exceeds 2 entries; reads resume after busy falls.
- Busy at end: busy=1 while the last 2 pixels sit in the FIFO -> state stays DRAIN; done fires one cycle after the final in_en; exactly 16384 in_en pulses total.
- Reset mid-frame: reset=0 after 5000 pixels -> in_en=0 and mem_rd=0 from the next cycle; a new start yields a full frame from address 0 that matches the golden data.
- Spurious start: start pulsed during RUN and again during DONE -> ignored; exactly one frame and one done pulse.
